// File: rtl/jump_pkg.sv
// Shared types for branch resolution: condition codes, sequencer states and
// the architectural flag register layout.
package jump_pkg;

    typedef enum logic [3:0] {
        COND_JMP  = 4'd0,
        COND_JZ   = 4'd1,
        COND_JB   = 4'd2,
        COND_JBE  = 4'd3,
        COND_JA   = 4'd4,
        COND_JAE  = 4'd5,
        COND_JG   = 4'd6,
        COND_JGE  = 4'd7,
        COND_JL   = 4'd8,
        COND_JLE  = 4'd9,
        COND_JNZ  = 4'd10,
        COND_NV11 = 4'd11,
        COND_NV12 = 4'd12,
        COND_NV13 = 4'd13,
        COND_NV14 = 4'd14,
        COND_NV15 = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Bit order matches the exported {OF,SF,CF,ZF} flag vector.
    typedef struct packed {
        logic of;
        logic sf;
        logic cf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational condition evaluator: decides whether a branch with the given
// condition code is taken under the given flags.
module jump_cond_eval
    import jump_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   taken
);

    always_comb begin
        // NOTE: default first so every path assigns taken; otherwise a latch is inferred.
        taken = 1'b0;
        case (cond)
            COND_JMP: taken = 1'b1;
            COND_JZ:  taken = flags.zf;
            COND_JB:  taken = flags.cf;
            COND_JBE: taken = flags.cf | flags.zf;
            COND_JA:  taken = ~flags.cf & ~flags.zf;
            COND_JAE: taken = ~flags.cf;
            COND_JG:  taken = ~flags.zf & (flags.sf == flags.of);
            COND_JGE: taken = (flags.sf == flags.of);
            COND_JL:  taken = (flags.sf != flags.of);
            COND_JLE: taken = flags.zf | (flags.sf != flags.of);
            COND_JNZ: taken = ~flags.zf;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: holds the flag register, accepts one branch at a time,
// waits for in-flight flags, resolves the condition and drives PC load/flush.
module branch_sequencer
    import jump_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_LIMIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flags_valid,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_sign,
    input  logic                  alu_overflow,
    input  logic                  flags_pending,
    input  logic                  br_valid,
    input  logic [3:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  br_ready,
    output logic                  stall,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  flush,
    output logic [3:0]            flags_out,
    output logic                  timeout_err
);

    localparam int WAIT_W  = $clog2(WAIT_LIMIT + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    state_e                state_q, state_d;
    cond_e                 cond_q, cond_d;
    flags_t                flags_q, flags_d;
    logic [ADDR_WIDTH-1:0] pc_target_q, pc_target_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  br_ready_q, br_ready_d;
    logic                  stall_q, stall_d;
    logic                  pc_load_q, pc_load_d;
    logic                  flush_q, flush_d;
    logic                  taken_next;

    always_comb begin
        flags_d = flags_q;
        if (flags_valid) begin
            flags_d = '{of: alu_overflow, sf: alu_sign, cf: alu_carry, zf: alu_zero};
        end
    end

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        pc_target_d = pc_target_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    cond_d      = cond_e'(br_cond);
                    pc_target_d = br_target;
                    if (flags_pending && !flags_valid) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_WAIT: begin
                if (flags_valid) begin
                    state_d = ST_EVAL;
                end else if (wait_cnt_q == WAIT_W'(WAIT_LIMIT - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_EVAL: begin
                // The taken decision was resolved on entry and is held in pc_load_q.
                if (pc_load_q) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Evaluating against next-cycle condition and flags lets pc_load be a flop
    // that is high exactly during EVAL, including when flags arrive with the accept.
    jump_cond_eval u_cond_eval (
        .cond  (cond_d),
        .flags (flags_d),
        .taken (taken_next)
    );

    always_comb begin
        br_ready_d = (state_d == ST_IDLE);
        stall_d    = (state_d == ST_WAIT) || (state_d == ST_EVAL);
        flush_d    = (state_d == ST_FLUSH);
        pc_load_d  = (state_d == ST_EVAL) && taken_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cond_q      <= COND_JMP;
            flags_q     <= '0;
            pc_target_q <= '0;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            br_ready_q  <= 1'b1;
            stall_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            cond_q      <= cond_d;
            flags_q     <= flags_d;
            pc_target_q <= pc_target_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
            br_ready_q  <= br_ready_d;
            stall_q     <= stall_d;
            pc_load_q   <= pc_load_d;
            flush_q     <= flush_d;
        end
    end

    assign br_ready    = br_ready_q;
    assign stall       = stall_q;
    assign pc_load     = pc_load_q;
    assign flush       = flush_q;
    assign pc_target   = pc_target_q;
    assign flags_out   = flags_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer with hand-computed
// expectations at default parameters (FLUSH_CYCLES=2, WAIT_LIMIT=15).
module tb_branch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        flags_valid;
    logic        alu_zero, alu_carry, alu_sign, alu_overflow;
    logic        flags_pending;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [15:0] br_target;
    logic        br_ready, stall, pc_load, flush, timeout_err;
    logic [15:0] pc_target;
    logic [3:0]  flags_out;

    int total = 0;
    int bad   = 0;
    logic seen_load;

    branch_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flags_valid   (flags_valid),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_sign      (alu_sign),
        .alu_overflow  (alu_overflow),
        .flags_pending (flags_pending),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .br_target     (br_target),
        .br_ready      (br_ready),
        .stall         (stall),
        .pc_load       (pc_load),
        .pc_target     (pc_target),
        .flush         (flush),
        .flags_out     (flags_out),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic z, input logic c, input logic s, input logic o);
        flags_valid  = 1'b1;
        alu_zero     = z;
        alu_carry    = c;
        alu_sign     = s;
        alu_overflow = o;
    endtask

    task automatic clr_flags();
        flags_valid  = 1'b0;
        alu_zero     = 1'b0;
        alu_carry    = 1'b0;
        alu_sign     = 1'b0;
        alu_overflow = 1'b0;
    endtask

    task automatic present(input logic [3:0] cond, input logic [15:0] tgt);
        br_valid  = 1'b1;
        br_cond   = cond;
        br_target = tgt;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_br_ready"}, br_ready, 1);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_pc_load"}, pc_load, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_pc_target"}, pc_target, 0);
        check({tag, "_flags_out"}, flags_out, 0);
        check({tag, "_timeout"}, timeout_err, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        flags_pending = 1'b0;
        br_valid      = 1'b0;
        br_cond       = 4'd0;
        br_target     = 16'h0000;
        clr_flags();
        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // JZ with ZF set the cycle before; target 0x0040
        set_flags(1, 0, 0, 0);
        tick();
        clr_flags();
        check("jz_flags", flags_out, 4'h1);
        present(4'd1, 16'h0040);
        check("jz_ready_T", br_ready, 1);
        tick();
        br_valid = 1'b0;
        check("jz_stall_T1", stall, 1);
        check("jz_load_T1", pc_load, 1);
        check("jz_target_T1", pc_target, 16'h0040);
        check("jz_ready_T1", br_ready, 0);
        check("jz_flush_T1", flush, 0);
        tick();
        check("jz_flush_T2", flush, 1);
        check("jz_load_T2", pc_load, 0);
        check("jz_stall_T2", stall, 0);
        present(4'd0, 16'hFFFF);
        tick();
        check("jz_flush_T3", flush, 1);
        check("jz_ignored_target", pc_target, 16'h0040);
        br_valid = 1'b0;
        tick();
        check("jz_flush_T4", flush, 0);
        check("jz_ready_T4", br_ready, 1);

        // JL with flags pending; SF=1,OF=0 arrives 3 cycles after accept
        present(4'd8, 16'h1234);
        flags_pending = 1'b1;
        tick();
        br_valid = 1'b0;
        check("jl_stall_T1", stall, 1);
        check("jl_ready_T1", br_ready, 0);
        check("jl_load_T1", pc_load, 0);
        tick();
        check("jl_stall_T2", stall, 1);
        tick();
        check("jl_stall_T3", stall, 1);
        set_flags(0, 0, 1, 0);
        flags_pending = 1'b0;
        tick();
        clr_flags();
        check("jl_stall_eval", stall, 1);
        check("jl_load_eval", pc_load, 1);
        check("jl_flags", flags_out, 4'h4);
        check("jl_target", pc_target, 16'h1234);
        tick();
        check("jl_flush", flush, 1);
        check("jl_stall_flush", stall, 0);
        tick();
        tick();
        check("jl_ready_back", br_ready, 1);

        // JG with ZF=0, SF=1, OF=1 -> taken
        set_flags(0, 0, 1, 1);
        tick();
        clr_flags();
        check("jg_flags", flags_out, 4'hC);
        present(4'd6, 16'h00AA);
        tick();
        br_valid = 1'b0;
        check("jg_load", pc_load, 1);
        tick();
        tick();
        tick();
        check("jg_ready_back", br_ready, 1);

        // JA with CF=1 -> not taken
        set_flags(0, 1, 0, 0);
        tick();
        clr_flags();
        check("ja_flags", flags_out, 4'h2);
        present(4'd4, 16'h0BBB);
        tick();
        br_valid = 1'b0;
        check("ja_load", pc_load, 0);
        check("ja_stall", stall, 1);
        check("ja_target", pc_target, 16'h0BBB);
        tick();
        check("ja_flush", flush, 0);
        check("ja_ready", br_ready, 1);
        check("ja_stall_after", stall, 0);

        // Timeout: pending held, no flags for WAIT_LIMIT cycles
        present(4'd0, 16'h0555);
        flags_pending = 1'b1;
        tick();
        br_valid  = 1'b0;
        seen_load = 1'b0;
        check("to_stall_T1", stall, 1);
        for (int i = 0; i < 14; i++) begin
            seen_load = seen_load | pc_load;
            tick();
        end
        check("to_not_yet", timeout_err, 0);
        check("to_stall_last", stall, 1);
        tick();
        seen_load = seen_load | pc_load;
        check("to_err", timeout_err, 1);
        check("to_ready", br_ready, 1);
        check("to_stall_off", stall, 0);
        check("to_no_load", seen_load, 0);
        flags_pending = 1'b0;
        present(4'd0, 16'h0777);
        tick();
        br_valid = 1'b0;
        check("to_next_load", pc_load, 1);
        check("to_next_target", pc_target, 16'h0777);
        tick();
        tick();
        tick();
        check("to_sticky", timeout_err, 1);
        check("to_next_ready", br_ready, 1);

        // flags_valid coincides with accept: EVAL must see ZF=1
        present(4'd1, 16'h0100);
        set_flags(1, 0, 0, 0);
        flags_pending = 1'b1;
        tick();
        br_valid      = 1'b0;
        flags_pending = 1'b0;
        clr_flags();
        check("coin_stall", stall, 1);
        check("coin_load", pc_load, 1);
        check("coin_flags", flags_out, 4'h1);
        tick();
        check("fl_flush", flush, 1);
        set_flags(0, 1, 1, 0);
        tick();
        clr_flags();
        check("fl_flags", flags_out, 4'h6);
        check("fl_flush2", flush, 1);
        tick();
        check("fl_ready", br_ready, 1);

        // Condition 12 never taken
        present(4'd12, 16'h0CCC);
        tick();
        br_valid = 1'b0;
        check("nv12_load", pc_load, 0);
        check("nv12_stall", stall, 1);
        tick();
        check("nv12_ready", br_ready, 1);
        check("nv12_flush", flush, 0);

        // Asynchronous reset during WAIT
        present(4'd0, 16'h0DDD);
        flags_pending = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        check("rw_stall", stall, 1);
        check("rw_target", pc_target, 16'h0DDD);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("rw_reset");
        flags_pending = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();

        // JNZ after reset: flags cleared, so taken
        present(4'd10, 16'h0EEE);
        tick();
        br_valid = 1'b0;
        check("jnz_load", pc_load, 1);
        check("jnz_target", pc_target, 16'h0EEE);
        tick();
        tick();
        tick();
        check("jnz_ready", br_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
